// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: operands are fed nibble-serially (LSB first) through one
// 4-bit fulladder, with the ripple carry held in a register between passes.

module fulladder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  always_comb begin
    {cout, s} = 5'(a) + 5'(b) + 5'(cin);
  end

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : gen_width_check
    $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [3:0]        fa_s;
  logic              fa_cout;
  logic [WIDTH+3:0]  sum_shift;

  fulladder u_fulladder (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New nibble enters at the top so the LSB nibble ends up at the bottom after NIBBLES passes.
  assign sum_shift = {fa_s, sum_q};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d   = sum_shift[WIDTH+3:4];
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = fa_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IdxW'(NIBBLES - 1)) begin
          cout_d  = fa_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16) with hand-computed expected results.

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge; scramble them afterwards to show they are not re-sampled.
  task automatic do_accept(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;
    chk("accept_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int lat;
  int seen;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

    // 1. Asynchronous reset asserted mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'h0000);
    chk("rst_cout", 32'(cout), 32'd0);
    #20 rst_n = 1'b1;

    // 2. Basic add and latency
    do_accept(16'h1234, 16'h1111, 1'b0);
    wait_done(lat);
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_sum", 32'(sum), 32'h2345);
    chk("t2_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    chk("t2_idle_out_valid", 32'(out_valid), 32'd0);
    chk("t2_idle_in_ready", 32'(in_ready), 32'd1);
    chk("t2_hold_sum", 32'(sum), 32'h2345);

    // 3. Full carry ripple
    do_accept(16'hFFFF, 16'h0000, 1'b1);
    wait_done(lat);
    chk("t3a_latency", 32'(lat), 32'd4);
    chk("t3a_sum", 32'(sum), 32'h0000);
    chk("t3a_cout", 32'(cout), 32'd1);
    @(posedge clk); #1;
    do_accept(16'h0FFF, 16'h0001, 1'b0);
    wait_done(lat);
    chk("t3b_sum", 32'(sum), 32'h1000);
    chk("t3b_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    // 4. Backpressure with an ignored in_valid pulse
    out_ready = 1'b0;
    do_accept(16'h8000, 16'h8000, 1'b0);
    wait_done(lat);
    chk("t4_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      a = 16'h0001; b = 16'h0000; cin = 1'b0; in_valid = (i == 1);
      @(posedge clk); #1;
      chk("t4_hold_out_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_sum", 32'(sum), 32'h0000);
      chk("t4_hold_cout", 32'(cout), 32'd1);
      chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_idle_out_valid", 32'(out_valid), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_sum", 32'(sum), 32'h0000);

    // 5. Back-to-back with in_valid held high
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'hABCD; b = 16'h1111;
    chk("t5a_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("t5a_latency", 32'(lat), 32'd4);
    chk("t5a_sum", 32'(sum), 32'h0100);
    chk("t5a_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    chk("t5_idle_in_ready", 32'(in_ready), 32'd1);
    chk("t5_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t5b_accepted", 32'(busy), 32'd1);
    wait_done(lat);
    chk("t5b_latency", 32'(lat), 32'd4);
    chk("t5b_sum", 32'(sum), 32'hBCDE);
    chk("t5b_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    // 6. Reset mid-RUN discards the operation
    do_accept(16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_sum", 32'(sum), 32'h0000);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("t6_no_out_valid", 32'(seen), 32'd0);
    do_accept(16'h0001, 16'h0001, 1'b1);
    wait_done(lat);
    chk("t6_latency", 32'(lat), 32'd4);
    chk("t6_sum", 32'(sum), 32'h0003);
    chk("t6_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
